// File: rtl/rt_ibex_pcs_pkg.sv
// Shared types and default sizing for the RT-Ibex preemptible context-save
// (PCS) nesting controller and its hardware LIFO.
//
// The default localparams are the single source of truth for the nesting
// geometry. The LIFO should be sized from NrHwSlotsDefault so that its depth
// and the controller's hardware slot count always match.
package rt_ibex_pcs_pkg;

    localparam int unsigned IrqLevelWidthDefault = 8;
    localparam int unsigned NrHwSlotsDefault     = 8;
    localparam int unsigned MaxNestDefault       = 16;

    // Storage width of a level inside a frame. The controller's IrqLevelWidth
    // must not exceed this width.
    localparam int unsigned PcsLevelWidth = IrqLevelWidthDefault;

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        RESTORE
    } pcs_state_e;

    // One nesting frame. hw=1 means the context lives in the hardware LIFO.
    // hw=0 means software saved it.
    typedef struct packed {
        logic                     hw;
        logic [PcsLevelWidth-1:0] level;
    } pcs_frame_t;

endpackage

// File: rtl/rt_ibex_pcs_level_stack.sv
// Level stack for the PCS controller. It holds one pcs_frame_t per active
// interrupt frame.
//
// Ports:
//   clk_i, rst_ni  clock and synchronous active-low reset
//   push_i         push frame_i; ignored when the stack is full
//   pop_i          pop the top frame; ignored when empty or when push_i is set
//   frame_i        frame to push
//   top_o          top frame; all-zero when the stack is empty
//   depth_o        number of live frames
//   hw_depth_o     number of live frames with hw=1
//   full_o         depth_o == Depth
//   empty_o        depth_o == 0
module rt_ibex_pcs_level_stack
    import rt_ibex_pcs_pkg::*;
#(
    parameter int unsigned Depth   = MaxNestDefault,
    parameter int unsigned HwSlots = NrHwSlotsDefault
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  pcs_frame_t                   frame_i,
    output pcs_frame_t                   top_o,
    output logic [$clog2(Depth+1)-1:0]   depth_o,
    output logic [$clog2(HwSlots+1)-1:0] hw_depth_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned DepthW = $clog2(Depth + 1);
    localparam int unsigned HwW    = $clog2(HwSlots + 1);
    localparam int unsigned IdxW   = (Depth > 1) ? $clog2(Depth) : 1;

    pcs_frame_t        mem_q [Depth];
    logic [DepthW-1:0] depth_q;
    logic [HwW-1:0]    hw_q;
    logic [IdxW-1:0]   wr_idx;
    logic [IdxW-1:0]   top_idx;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (depth_q == DepthW'(Depth));
    assign empty_o = (depth_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o && !push_i;

    // wr_idx truncates when the stack is full. It is only used while do_push
    // is set, and do_push is never set when full.
    assign wr_idx  = IdxW'(depth_q);
    assign top_idx = IdxW'(depth_q - DepthW'(1));

    assign top_o      = empty_o ? '0 : mem_q[top_idx];
    assign depth_o    = depth_q;
    assign hw_depth_o = hw_q;

    // NOTE: the frame storage has no reset. The depth counter alone defines
    // which entries are live, so resetting the array would only add logic.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_idx] <= frame_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments. Every register
    // then updates from its pre-edge value, whatever the statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            depth_q <= '0;
            hw_q    <= '0;
        end else if (do_push) begin
            depth_q <= depth_q + DepthW'(1);
            hw_q    <= hw_q + HwW'(frame_i.hw);
        end else if (do_pop) begin
            depth_q <= depth_q - DepthW'(1);
            hw_q    <= hw_q - HwW'(top_o.hw);
        end
    end

endmodule

// File: rtl/rt_ibex_pcs_ctrl.sv
// RT-Ibex preemptible context-save nesting controller.
//
// The controller keeps a level stack of active interrupt frames and decides
// whether a pending request may preempt the current frame. It sequences the
// hardware context LIFO for store and restore, and stalls the core while the
// LIFO shifts. Once the hardware slots are exhausted, it grants further
// frames with a software-save flag, up to MaxNest frames in total.
//
// Ports:
//   clk_i, rst_ni        clock and synchronous active-low reset
//   irq_req_i            level-held interrupt request
//   irq_level_i          level of the pending request
//   irq_grant_o          one-cycle pulse: request accepted
//   irq_sw_save_o        qualified by irq_grant_o: software must save the frame
//   mret_i               one-cycle pulse: core retires an mret
//   mret_done_o          one-cycle pulse: context restored, core may resume
//   lifo_irq_ack_o       LIFO store trigger
//   lifo_next_mret_o     LIFO restore trigger
//   lifo_restore_en_i    LIFO restore data valid
//   core_stall_o         hold the core pipeline
//   curr_level_o         level of the top frame; 0 when the stack is empty
//   hw_depth_o           number of live hardware frames
//   nest_depth_o         total number of live frames
//   err_o                one-cycle pulse: mret_i with an empty stack, or
//                        mret_i while a save or restore is in progress
//
// Optional build macro RT_IBEX_PCS_STATS_EN adds these outputs:
//   max_depth_o          high-water mark of nest_depth_o
//   sw_fallback_cnt_o    saturating count of software-save grants
module rt_ibex_pcs_ctrl
    import rt_ibex_pcs_pkg::*;
#(
    parameter int unsigned IrqLevelWidth = IrqLevelWidthDefault,
    parameter int unsigned NrHwSlots     = NrHwSlotsDefault,
    parameter int unsigned MaxNest       = MaxNestDefault
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           irq_req_i,
    input  logic [IrqLevelWidth-1:0]       irq_level_i,
    output logic                           irq_grant_o,
    output logic                           irq_sw_save_o,
    input  logic                           mret_i,
    output logic                           mret_done_o,
    output logic                           lifo_irq_ack_o,
    output logic                           lifo_next_mret_o,
    input  logic                           lifo_restore_en_i,
    output logic                           core_stall_o,
    output logic [IrqLevelWidth-1:0]       curr_level_o,
    output logic [$clog2(NrHwSlots+1)-1:0] hw_depth_o,
    output logic [$clog2(MaxNest+1)-1:0]   nest_depth_o,
`ifdef RT_IBEX_PCS_STATS_EN
    output logic [$clog2(MaxNest+1)-1:0]   max_depth_o,
    output logic [15:0]                    sw_fallback_cnt_o,
`endif
    output logic                           err_o
);

    localparam int unsigned HwW = $clog2(NrHwSlots + 1);

    pcs_state_e state_q, state_d;
    logic       sw_done_q, sw_done_d;
    logic       push, pop;
    pcs_frame_t push_frame;
    pcs_frame_t top_frame;
    logic       stack_full;
    logic       stack_empty;
    logic       hw_full;
    logic       preempt;

    rt_ibex_pcs_level_stack #(
        .Depth   (MaxNest),
        .HwSlots (NrHwSlots)
    ) u_level_stack (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push),
        .pop_i      (pop),
        .frame_i    (push_frame),
        .top_o      (top_frame),
        .depth_o    (nest_depth_o),
        .hw_depth_o (hw_depth_o),
        .full_o     (stack_full),
        .empty_o    (stack_empty)
    );

    assign curr_level_o = top_frame.level[IrqLevelWidth-1:0];
    assign hw_full      = (hw_depth_o == HwW'(NrHwSlots));

    // A strictly higher level is required; an equal level never preempts.
    // Level 0 can never exceed curr_level_o, so thread mode never preempts.
    assign preempt = irq_req_i && (irq_level_i > curr_level_o) && !stack_full;

    assign push_frame.hw    = !hw_full;
    assign push_frame.level = PcsLevelWidth'(irq_level_i);

    // NOTE: every signal in this block gets a default before the case
    // statement, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        sw_done_d        = 1'b0;
        irq_grant_o      = 1'b0;
        irq_sw_save_o    = 1'b0;
        lifo_irq_ack_o   = 1'b0;
        lifo_next_mret_o = 1'b0;
        core_stall_o     = 1'b0;
        mret_done_o      = 1'b0;
        err_o            = 1'b0;
        push             = 1'b0;
        pop              = 1'b0;

        // Reset is synchronous, so the Mealy outputs are gated here. This
        // keeps every output at 0 during the reset cycle itself.
        if (rst_ni) begin
            mret_done_o = sw_done_q;
            unique case (state_q)
                IDLE: begin
                    // mret wins over a same-cycle request. The request is
                    // held, so it is re-evaluated on a later IDLE cycle
                    // against the post-pop level.
                    if (mret_i) begin
                        if (stack_empty) begin
                            err_o = 1'b1;
                        end else if (top_frame.hw) begin
                            lifo_next_mret_o = 1'b1;
                            core_stall_o     = 1'b1;
                            state_d          = RESTORE;
                        end else begin
                            pop       = 1'b1;
                            sw_done_d = 1'b1;
                        end
                    end else if (preempt) begin
                        irq_grant_o = 1'b1;
                        push        = 1'b1;
                        if (hw_full) begin
                            irq_sw_save_o = 1'b1;
                        end else begin
                            lifo_irq_ack_o = 1'b1;
                            core_stall_o   = 1'b1;
                            state_d        = SAVE;
                        end
                    end
                end
                SAVE: begin
                    core_stall_o = 1'b1;
                    err_o        = mret_i;
                    state_d      = IDLE;
                end
                RESTORE: begin
                    core_stall_o = 1'b1;
                    err_o        = mret_i;
                    if (lifo_restore_en_i) begin
                        mret_done_o = 1'b1;
                        pop         = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            sw_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_done_q <= sw_done_d;
        end
    end

`ifdef RT_IBEX_PCS_STATS_EN
    logic [$clog2(MaxNest+1)-1:0] max_depth_q;
    logic [15:0]                  sw_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            max_depth_q <= '0;
            sw_cnt_q    <= '0;
        end else begin
            if (nest_depth_o > max_depth_q) begin
                max_depth_q <= nest_depth_o;
            end
            if (irq_grant_o && irq_sw_save_o && (sw_cnt_q != '1)) begin
                sw_cnt_q <= sw_cnt_q + 16'd1;
            end
        end
    end

    assign max_depth_o       = max_depth_q;
    assign sw_fallback_cnt_o = sw_cnt_q;
`endif

endmodule

// File: tb/tb_rt_ibex_pcs_ctrl.sv
// Self-checking bench for rt_ibex_pcs_ctrl with default parameters
// (8-bit levels, 8 hardware slots, 16 nesting frames).
//
// The bench keeps a reference model: a queue of {hw, level} frames plus the
// pending save, restore and done obligations. On every negedge after reset it
// compares the DUT outputs against that model. Directed steps also carry
// hand-computed literal expectations. A small LIFO model answers each restore
// trigger with lifo_restore_en one cycle after the controller enters its
// restore phase.
module tb_rt_ibex_pcs_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       irq_req;
    logic [7:0] irq_level;
    logic       irq_grant;
    logic       irq_sw_save;
    logic       mret;
    logic       mret_done;
    logic       lifo_irq_ack;
    logic       lifo_next_mret;
    logic       lifo_restore_en;
    logic       core_stall;
    logic [7:0] curr_level;
    logic [3:0] hw_depth;
    logic [4:0] nest_depth;
    logic       err;
`ifdef RT_IBEX_PCS_STATS_EN
    logic [4:0]  max_depth;
    logic [15:0] sw_fallback_cnt;
`endif

    always #5 clk = ~clk;

    rt_ibex_pcs_ctrl dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .irq_req_i         (irq_req),
        .irq_level_i       (irq_level),
        .irq_grant_o       (irq_grant),
        .irq_sw_save_o     (irq_sw_save),
        .mret_i            (mret),
        .mret_done_o       (mret_done),
        .lifo_irq_ack_o    (lifo_irq_ack),
        .lifo_next_mret_o  (lifo_next_mret),
        .lifo_restore_en_i (lifo_restore_en),
        .core_stall_o      (core_stall),
        .curr_level_o      (curr_level),
        .hw_depth_o        (hw_depth),
        .nest_depth_o      (nest_depth),
`ifdef RT_IBEX_PCS_STATS_EN
        .max_depth_o       (max_depth),
        .sw_fallback_cnt_o (sw_fallback_cnt),
`endif
        .err_o             (err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit hw;
        int level;
    } mframe_t;

    typedef struct packed {
        bit grant;
        bit sw;
        bit ack;
        bit nmret;
        bit stall;
        bit done;
        bit err;
        bit take_mret;
        bit preempt;
    } exp_t;

    mframe_t stk[$];
    int      save_left = 0;   // stall cycles still owed by a hardware store
    bit      restoring = 0;   // waiting for the LIFO restore
    bit      done_pend = 0;   // software pop: done pulse due next cycle
    bit      model_ok  = 0;
    int      m_max     = 0;
    int      m_sw_cnt  = 0;

    function automatic int hw_count();
        int n = 0;
        foreach (stk[i]) if (stk[i].hw) n++;
        return n;
    endfunction

    function automatic int top_level();
        return (stk.size() == 0) ? 0 : stk[stk.size()-1].level;
    endfunction

    function automatic exp_t eval();
        exp_t e;
        bit   busy;
        e    = '0;
        busy = (save_left > 0) || restoring;
        if (!rst_n) return e;
        e.err       = mret && (busy || stk.size() == 0);
        e.take_mret = !busy && mret && stk.size() > 0;
        e.preempt   = !busy && !mret && irq_req && (int'(irq_level) > top_level()) && stk.size() < 16;
        e.grant     = e.preempt;
        e.sw        = e.preempt && hw_count() >= 8;
        e.ack       = e.preempt && hw_count() < 8;
        e.nmret     = e.take_mret && stk[stk.size()-1].hw;
        e.stall     = busy || e.ack || e.nmret;
        e.done      = done_pend || (restoring && lifo_restore_en);
        return e;
    endfunction

    always @(posedge clk) begin : model_update
        exp_t    e;
        bit      nd;
        mframe_t f;
        e  = eval();
        nd = 0;
        if (!rst_n) begin
            stk.delete();
            save_left = 0;
            restoring = 0;
            done_pend = 0;
            m_max     = 0;
            m_sw_cnt  = 0;
            model_ok  = 1;
        end else begin
            if (stk.size() > m_max) m_max = stk.size();
            if (e.grant && e.sw && m_sw_cnt < 65535) m_sw_cnt++;
            if (save_left > 0) save_left--;
            if (restoring && lifo_restore_en) begin
                void'(stk.pop_back());
                restoring = 0;
            end
            if (e.take_mret) begin
                if (stk[stk.size()-1].hw) restoring = 1;
                else begin
                    void'(stk.pop_back());
                    nd = 1;
                end
            end else if (e.preempt) begin
                f.hw    = (hw_count() < 8);
                f.level = int'(irq_level);
                stk.push_back(f);
                if (f.hw) save_left = 1;
            end
            done_pend = nd;
        end
    end

    always @(negedge clk) begin : compare
        exp_t e;
        if (model_ok) begin
            e = eval();
            check("irq_grant", irq_grant, e.grant);
            check("irq_sw_save", irq_sw_save, e.sw);
            check("lifo_irq_ack", lifo_irq_ack, e.ack);
            check("lifo_next_mret", lifo_next_mret, e.nmret);
            check("core_stall", core_stall, e.stall);
            check("mret_done", mret_done, e.done);
            check("err", err, e.err);
            check("curr_level", curr_level, top_level());
            check("hw_depth", hw_depth, hw_count());
            check("nest_depth", nest_depth, stk.size());
`ifdef RT_IBEX_PCS_STATS_EN
            check("max_depth", max_depth, m_max);
            check("sw_fallback_cnt", sw_fallback_cnt, m_sw_cnt);
`endif
        end
    end

    // ---------------- LIFO model ----------------
    int lifo_delay = 0;

    always @(negedge clk) if (lifo_next_mret === 1'b1) lifo_delay = 2;

    always @(posedge clk) begin
        #1;
        lifo_restore_en = 1'b0;
        if (lifo_delay > 0) begin
            lifo_delay--;
            if (lifo_delay == 0) lifo_restore_en = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_irq(input int lvl);
        irq_req   = 1'b1;
        irq_level = 8'(lvl);
        cyc();
        irq_req = 1'b0;
        cyc();
    endtask

    task automatic do_mret();
        bit seen;
        seen = 0;
        mret = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (mret_done) seen = 1;
            cyc();
            mret = 1'b0;
        end
        check("mret_done_seen", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        irq_req         = 1'b0;
        irq_level       = 8'd0;
        mret            = 1'b0;
        lifo_restore_en = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_nest", nest_depth, 0);
        check("rst_curr", curr_level, 0);
        check("rst_stall", core_stall, 0);

        // 1: first grant, hardware store
        cyc();
        irq_req   = 1'b1;
        irq_level = 8'd5;
        @(negedge clk);
        check("t1_grant", irq_grant, 1);
        check("t1_ack", lifo_irq_ack, 1);
        check("t1_stall_c0", core_stall, 1);
        cyc();
        irq_req = 1'b0;
        @(negedge clk);
        check("t1_stall_c1", core_stall, 1);
        check("t1_curr", curr_level, 5);
        check("t1_hw", hw_depth, 1);
        cyc();
        @(negedge clk);
        check("t1_stall_c2", core_stall, 0);

        // 2: an equal or lower level does not preempt; a higher one does
        cyc();
        irq_req   = 1'b1;
        irq_level = 8'd5;
        @(negedge clk);
        check("t2_eq_nogrant", irq_grant, 0);
        cyc();
        irq_level = 8'd3;
        @(negedge clk);
        check("t2_lo_nogrant", irq_grant, 0);
        cyc();
        irq_level = 8'd7;
        @(negedge clk);
        check("t2_hi_grant", irq_grant, 1);
        cyc();
        irq_req = 1'b0;
        @(negedge clk);
        check("t2_curr", curr_level, 7);
        check("t2_nest", nest_depth, 2);
        cyc();

        // 3: exhaust the hardware slots, then fall back to software save
        do_mret();
        do_mret();
        for (int l = 1; l <= 8; l++) do_irq(l);
        irq_req   = 1'b1;
        irq_level = 8'd9;
        @(negedge clk);
        check("t3_grant", irq_grant, 1);
        check("t3_sw", irq_sw_save, 1);
        check("t3_noack", lifo_irq_ack, 0);
        check("t3_hw", hw_depth, 8);
        check("t3_nostall", core_stall, 0);
        cyc();
        irq_req = 1'b0;
        mret    = 1'b1;
        @(negedge clk);
        check("t3_nonmret", lifo_next_mret, 0);
        check("t3_nostall_m", core_stall, 0);
        cyc();
        mret = 1'b0;
        @(negedge clk);
        check("t3_done", mret_done, 1);
        check("t3_curr", curr_level, 8);
        cyc();

        // 4: hardware restore with a two-cycle done latency
        mret = 1'b1;
        @(negedge clk);
        check("t4_nmret", lifo_next_mret, 1);
        check("t4_stall_c0", core_stall, 1);
        cyc();
        mret = 1'b0;
        @(negedge clk);
        check("t4_stall_c1", core_stall, 1);
        check("t4_nodone_c1", mret_done, 0);
        cyc();
        @(negedge clk);
        check("t4_done_c2", mret_done, 1);
        cyc();
        @(negedge clk);
        check("t4_hw", hw_depth, 7);
        check("t4_curr", curr_level, 7);
        check("t4_stall_c3", core_stall, 0);

        // 5: mret and a request in the same cycle; the restore goes first
        do_mret();
        do_mret();
        do_mret();
        mret      = 1'b1;
        irq_req   = 1'b1;
        irq_level = 8'd9;
        @(negedge clk);
        check("t5_nogrant_c0", irq_grant, 0);
        check("t5_nmret", lifo_next_mret, 1);
        cyc();
        mret = 1'b0;
        cyc();
        @(negedge clk);
        check("t5_nogrant_c2", irq_grant, 0);
        cyc();
        @(negedge clk);
        check("t5_grant_c3", irq_grant, 1);
        check("t5_postpop", curr_level, 3);
        cyc();
        irq_req = 1'b0;
        cyc();

        // 6: fill to the nesting limit, then check empty mret and reset in SAVE
        for (int l = 10; l <= 21; l++) do_irq(l);
        irq_req   = 1'b1;
        irq_level = 8'd30;
        @(negedge clk);
        check("t6_full_nogrant", irq_grant, 0);
        check("t6_nest", nest_depth, 16);
        cyc(2);
        irq_req = 1'b0;
        cyc();
        for (int k = 0; k < 16; k++) do_mret();
        mret = 1'b1;
        @(negedge clk);
        check("t6_err", err, 1);
        cyc();
        mret = 1'b0;
        @(negedge clk);
        check("t6_err_clr", err, 0);
        cyc();
        irq_req   = 1'b1;
        irq_level = 8'd2;
        cyc();
        irq_req = 1'b0;
        rst_n   = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rst_stall", core_stall, 0);
        check("t6_rst_nest", nest_depth, 0);
        check("t6_rst_curr", curr_level, 0);
        check("t6_rst_done", mret_done, 0);
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rt_ibex_pcs_ctrl.md
Name: rt_ibex_pcs_ctrl

Overview:
- Nesting controller that sequences the hardware context-save LIFO for preemptible interrupts on the RT-Ibex core.
- Keeps a level stack of active interrupt frames and decides whether an incoming request may preempt the current one.
- Drives the LIFO store and restore handshakes and stalls the core while the LIFO shifts.
- When the hardware slots are exhausted, falls back to software save up to a hard nesting limit.

Parameters:
- IrqLevelWidth, 8, width of an interrupt priority level; level 0 means thread mode, never preempts.
- NrHwSlots, 8, hardware LIFO depth; must equal the depth of the attached LIFO.
- MaxNest, 16, total nesting limit (hardware + software frames); must be >= NrHwSlots.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset, synchronous, active-low
- irq_req_i  in  1  pending interrupt request from the interrupt controller, level-held
- irq_level_i  in  IrqLevelWidth  level of the pending request
- irq_grant_o  out  1  one-cycle pulse: request accepted, core may enter the handler
- irq_sw_save_o  out  1  qualified by irq_grant_o: frame must be saved by software
- mret_i  in  1  one-cycle pulse: core is retiring an mret
- mret_done_o  out  1  one-cycle pulse: context restored, core may resume
- lifo_irq_ack_o  out  1  to LIFO store trigger
- lifo_next_mret_o  out  1  to LIFO restore trigger
- lifo_restore_en_i  in  1  from LIFO: restore data valid this cycle
- core_stall_o  out  1  hold core pipeline
- curr_level_o  out  IrqLevelWidth  level of the top frame; 0 when the stack is empty
- hw_depth_o  out  $clog2(NrHwSlots+1)  number of hardware frames live
- nest_depth_o  out  $clog2(MaxNest+1)  total number of frames live
- err_o  out  1  one-cycle pulse: mret_i received with an empty stack

Behaviour:
- Reset: all outputs 0, stack empty, FSM in IDLE. Reset asserted in any state aborts the operation; no pulse is emitted afterwards.
- Level stack: MaxNest entries of {hw bit, level}. Push on grant, pop on mret completion. curr_level_o reflects the top entry.
- Preempt condition, evaluated in IDLE only: irq_req_i && irq_level_i > curr_level_o && nest_depth_o < MaxNest. Equal level never preempts.
- At nest_depth_o == MaxNest the request is ignored (held off) and no grant is issued.
- FSM states: IDLE, SAVE, RESTORE.
- IDLE, preempt, hw_depth_o < NrHwSlots:
  - Assert irq_grant_o, lifo_irq_ack_o and core_stall_o in the same cycle.
  - Push {1, level}; go to SAVE.
- IDLE, preempt, hw slots full:
  - Assert irq_grant_o with irq_sw_save_o=1; no LIFO activity, no stall.
  - Push {0, level}; stay in IDLE.
- SAVE: core_stall_o=1 for exactly one cycle while the LIFO shifts, then IDLE. Grant-to-handler latency is 2 cycles.
- IDLE, mret_i, top entry hw=1:
  - Assert lifo_next_mret_o and core_stall_o; go to RESTORE.
- IDLE, mret_i, top entry hw=0:
  - Pop and assert mret_done_o next cycle; no stall.
- IDLE, mret_i, stack empty: pulse err_o; no state change.
- RESTORE: core_stall_o=1 until lifo_restore_en_i. In that cycle assert mret_done_o, pop, and return to IDLE. mret_done_o is therefore 2 cycles after mret_i for a healthy LIFO.
- mret_i and a preempting irq_req_i in the same IDLE cycle: mret has priority. The request is re-evaluated against the post-pop level on a later IDLE cycle.
- mret_i arriving in SAVE or RESTORE is a protocol violation: it is ignored and err_o is pulsed.
- hw_depth_o and nest_depth_o never wrap; they saturate at their limits by construction.

Optional Feature:
- RT_IBEX_PCS_STATS_EN defined: adds output max_depth_o (width of nest_depth_o), the high-water mark of nest_depth_o. Also adds output sw_fallback_cnt_o (16 bit, saturating), which counts grants with irq_sw_save_o=1. Both are cleared only by reset.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package rt_ibex_pcs_pkg holds:
  - pcs_state_e (IDLE, SAVE, RESTORE)
  - pcs_frame_t {hw bit, level}
  - default-parameter localparams, shared with the LIFO so NrHwSlots and LIFO depth stay matched.
- One sub-module, rt_ibex_pcs_level_stack: push/pop stack of pcs_frame_t with depth, top and full/empty outputs.
- The FSM and preemption compare stay in rt_ibex_pcs_ctrl.

Test Plan:
1. Reset, then irq_req_i=1, level=5 -> irq_grant_o and lifo_irq_ack_o at cycle 0, core_stall_o for cycles 0-1, curr_level_o=5, hw_depth_o=1.
2. Level 5 active; request level 5, then level 3 -> no grant. Then level 7 -> grant, curr_level_o=7, nest_depth_o=2.
3. Nest levels 1..9 (NrHwSlots=8) -> the 9th grant has irq_sw_save_o=1 with no lifo_irq_ack_o and hw_depth_o=8. The subsequent mret gives mret_done_o with no lifo_next_mret_o and curr_level_o=8.
4. Hardware frame active; mret_i, with the LIFO model returning lifo_restore_en_i one cycle later -> mret_done_o 2 cycles after mret_i, stall during the gap, depth decremented.
5. Same cycle: mret_i and irq_req_i at level 9 over top level 4 -> restore is taken first. The grant follows on the first IDLE cycle, compared against the post-pop level.
6. Fill to MaxNest=16 -> further requests ignored. mret_i on an empty stack -> err_o pulse. Reset asserted in SAVE -> IDLE, all outputs 0 next cycle.
